// File: rtl/dmi_arbiter.sv
// dmi_arbiter: shares the Debug Module's single DMI slave port between two DTMs.
// Each port's one-cycle request pulse is captured in a pending buffer. One
// transaction at a time is issued to the DM, with round-robin choice when both
// ports are pending, and the DM response is routed back to the port that owns it.
// Optional feature macro: DMI_ARB_TIMEOUT_EN. When defined, a WAIT that lasts
// TIMEOUT_CYCLES completes with TIMEOUT_DATA and sets the sticky timeout_err.
module dmi_arbiter #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_valid,
  input  logic [6:0]  m0_req_addr,
  input  logic [31:0] m0_req_data,
  input  logic [1:0]  m0_req_op,
  output logic        m0_rsp_valid,
  output logic [31:0] m0_rsp_data,
  input  logic        m1_req_valid,
  input  logic [6:0]  m1_req_addr,
  input  logic [31:0] m1_req_data,
  input  logic [1:0]  m1_req_op,
  output logic        m1_rsp_valid,
  output logic [31:0] m1_rsp_data,
  output logic        s_req_valid,
  output logic [6:0]  s_req_addr,
  output logic [31:0] s_req_data,
  output logic [1:0]  s_req_op,
  input  logic        s_rsp_valid,
  input  logic [31:0] s_rsp_data,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        pend0_q, pend1_q;
  logic        last_q;   // port granted most recently; loses the next tie
  logic        gnt_q;    // owner of the transaction in flight
  logic [6:0]  a0_q, a1_q;
  logic [31:0] d0_q, d1_q;
  logic [1:0]  o0_q, o1_q;
  logic [6:0]  s_addr_q;
  logic [31:0] s_data_q;
  logic [1:0]  s_op_q;
  logic        rsp0_v_q, rsp1_v_q;
  logic [31:0] rsp0_d_q, rsp1_d_q;
  logic        sel, take, done, tmo_hit;
  logic [31:0] done_data;

  // Single pending port wins outright; on a tie the port not granted last wins.
  assign sel       = (pend0_q & pend1_q) ? ~last_q : pend1_q;
  assign take      = (state_q == IDLE) & (pend0_q | pend1_q);
  assign done      = (state_q == WAIT) & (s_rsp_valid | tmo_hit);
  assign done_data = s_rsp_valid ? s_rsp_data : TIMEOUT_DATA;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcnt_q;
  logic          terr_q;

  // Counts WAIT cycles; fires on the TIMEOUT_CYCLES-th one without a response.
  assign tmo_hit     = (state_q == WAIT) & ~s_rsp_valid & (tcnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = terr_q;

  // Timeout counter cleared while issuing, so it starts at 0 on WAIT entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)     tcnt_q <= '0;
      else if (state_q == WAIT) tcnt_q <= tcnt_q + 1'b1;
      if (tmo_hit)              terr_q <= 1'b1;
    end
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo  = 32'(TIMEOUT_CYCLES);
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one transaction at a time, ISSUE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    s_req_valid = 1'b0;
    busy        = 1'b0;
    if (state_q == ISSUE) s_req_valid = 1'b1;
    if (state_q != IDLE)  busy        = 1'b1;
  end

  // Pending buffers, grant latch and response routing.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend0_q  <= 1'b0;  pend1_q <= 1'b0;
      last_q   <= 1'b1;  gnt_q   <= 1'b0;
      a0_q     <= '0;    a1_q    <= '0;
      d0_q     <= '0;    d1_q    <= '0;
      o0_q     <= '0;    o1_q    <= '0;
      s_addr_q <= '0;    s_data_q <= '0;  s_op_q <= '0;
      rsp0_v_q <= 1'b0;  rsp1_v_q <= 1'b0;
      rsp0_d_q <= '0;    rsp1_d_q <= '0;
    end else begin
      rsp0_v_q <= 1'b0;
      rsp1_v_q <= 1'b0;
      // A pulse into an occupied buffer is dropped; the buffer keeps its request.
      if (m0_req_valid && !pend0_q) begin
        pend0_q <= 1'b1;
        a0_q    <= m0_req_addr;
        d0_q    <= m0_req_data;
        o0_q    <= m0_req_op;
      end
      if (m1_req_valid && !pend1_q) begin
        pend1_q <= 1'b1;
        a1_q    <= m1_req_addr;
        d1_q    <= m1_req_data;
        o1_q    <= m1_req_op;
      end
      if (take) begin
        gnt_q    <= sel;
        s_addr_q <= sel ? a1_q : a0_q;
        s_data_q <= sel ? d1_q : d0_q;
        s_op_q   <= sel ? o1_q : o0_q;
      end
      if (done) begin
        last_q <= gnt_q;
        if (gnt_q) begin
          rsp1_v_q <= 1'b1;
          rsp1_d_q <= done_data;
          pend1_q  <= 1'b0;
        end else begin
          rsp0_v_q <= 1'b1;
          rsp0_d_q <= done_data;
          pend0_q  <= 1'b0;
        end
      end
    end
  end

  assign s_req_addr   = s_addr_q;
  assign s_req_data   = s_data_q;
  assign s_req_op     = s_op_q;
  assign m0_rsp_valid = rsp0_v_q;
  assign m0_rsp_data  = rsp0_d_q;
  assign m1_rsp_valid = rsp1_v_q;
  assign m1_rsp_data  = rsp1_d_q;

endmodule
